logic_gate_unit: RTL
====================

Name: logic_gate_unit

Overview:
Parametrised, registered successor to the single 2-input gate cell.
- Applies one of eight bitwise operations to WIDTH-bit operands.
- Can fold a burst of operands into one result (accumulate mode).
- Presents results through a valid/ready output register.
- Sits between operand producers and downstream datapath logic that needs flow-controlled gate results.

Parameters:
WIDTH, 8, operand/result bit width (>=1)
MAX_BEATS, 16, max beats folded into one accumulate result before forced termination (2..255)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand beat offered
in_ready  output  1  block can accept beat this cycle
op  input  3  operation select, sampled with beat
a  input  WIDTH  operand A
b  input  WIDTH  operand B
acc_en  input  1  beat belongs to accumulate burst, sampled with beat
last  input  1  final beat of accumulate burst (ignored when acc_en=0)
out_valid  output  1  result held in c is valid
out_ready  input  1  downstream accepts result
c  output  WIDTH  registered result
beats  output  8  number of beats folded into c (1 for non-accumulate)
trunc  output  1  burst force-terminated at MAX_BEATS

Behaviour:
- Clock/reset: single clock clk. rst is synchronous, active-high; acts on the rising edge of clk.
- Op encoding, f(x,y):
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR
  - 6 NOT x (y ignored), 7 PASS x
  - All bitwise across WIDTH.
- Handshake:
  - Beat accepted when in_valid & in_ready.
  - Result consumed when out_valid & out_ready.
  - in_ready = (state != HOLD) | out_ready, combinational.
- States: IDLE, ACC, HOLD.
- IDLE, beat accepted:
  - acc_en=0: c<=f(a,b), beats<=1, trunc<=0, go HOLD.
  - acc_en=1: acc<=f(a,b), count<=1.
    - last=1: transfer to c, go HOLD.
    - last=0: go ACC.
- ACC, beat accepted (a ignored, op taken from current beat):
  - acc<=f(acc,b), count<=count+1.
  - last=1: c<=new acc, beats<=count+1, trunc<=0, go HOLD.
  - count+1==MAX_BEATS with last=0: c<=new acc, beats<=MAX_BEATS, trunc<=1, go HOLD. Subsequent beats start a fresh burst.
  - acc_en=0 during ACC is treated as acc_en=1.
- HOLD:
  - out_valid=1; c, beats, trunc stable until consumed.
  - out_ready=1 with no accepted beat: go IDLE.
  - out_ready=1 with accepted beat: consume and process the new beat exactly as from IDLE in the same cycle. Gives full throughput, one result per cycle.
- Latency: one cycle, accepting edge to out_valid for non-accumulate beats; one cycle after the last/terminating beat for bursts.
- out_valid deasserts only on consumption, never spontaneously.
- Reset values:
  - state=IDLE, out_valid=0, c=0, beats=0, trunc=0.
  - Internal acc and count = 0.
  - in_ready=1 after reset.
- Reset mid-burst or while HOLD: partial accumulation and pending result discarded; no output beat produced.
- op values are always legal (3-bit, all codes defined).

Optional Feature:
Macro LOGIC_GATE_PARITY_EN.
- Defined: extra output port c_par (1 bit) = XOR-reduction of the value loaded into c. Registered in the same cycle as c, held with it, reset to 0.
- Undefined: port c_par and its register absent; all other behaviour identical.

Test Plan:
- Non-accumulate, WIDTH=8, out_ready=1:
  - a=8'hF0, b=8'h3C, op=0 -> next cycle c=8'h30, beats=1, trunc=0, out_valid=1.
  - Repeat with op=2 -> c=8'hCC; op=4 -> c=8'h03.
- Back-to-back, in_valid held 4 cycles, ops 1,3,5,6 with a=8'hAA, b=8'h0F, out_ready=1:
  - in_ready stays 1.
  - c sequence 8'hAF, 8'hF5, 8'h5A, 8'h55 on consecutive cycles.
- Backpressure: result pending with out_ready=0 for 3 cycles and in_valid=1:
  - in_ready=0, c stable, no beat lost.
  - out_ready=1 -> old result consumed and new beat accepted in the same cycle.
- Accumulate AND burst, op=0: a=8'hFF, b=8'hFF (first beat), then b=8'h7E, b=8'h3C with last=1:
  - c=8'h3C, beats=3, trunc=0.
- Truncation, MAX_BEATS=4: acc_en=1, last=0 for 6 beats, op=1, b=8'h01<<i:
  - First result after beat 4 is c=8'h0F, beats=4, trunc=1.
  - Beats 5-6 start a new burst.
- Reset mid-burst after 2 beats:
  - out_valid=0, c=0.
  - A following single beat a=8'h55, b=8'hFF, op=0, acc_en=0 -> c=8'h55, beats=1.
  - With LOGIC_GATE_PARITY_EN, c_par=0.

Source files
------------

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered bitwise gate with burst accumulation and a valid/ready result register.
// Optional macro LOGIC_GATE_PARITY_EN adds c_par, the XOR-reduction of the value held in c.
module logic_gate_unit #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_en,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [7:0]       beats,
  output logic             trunc
`ifdef LOGIC_GATE_PARITY_EN
  ,
  output logic             c_par
`endif
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [7:0]       count;
  logic             accept;
  logic             load_c;
  logic             in_acc;
  logic [WIDTH-1:0] fresh_res;
  logic [WIDTH-1:0] fold_res;
  logic [WIDTH-1:0] load_val;
  logic [7:0]       count_inc;

  function automatic logic [WIDTH-1:0] gate_f(input logic [2:0] sel,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (sel)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = x ^ y;
      3'd3:    r = ~(x & y);
      3'd4:    r = ~(x | y);
      3'd5:    r = ~(x ^ y);
      3'd6:    r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  assign in_ready  = (state != HOLD) | out_ready;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;
  assign in_acc    = (state == ACC);
  assign fresh_res = gate_f(op, a, b);
  assign fold_res  = gate_f(op, acc, b);
  assign count_inc = count + 8'd1;
  assign load_val  = in_acc ? fold_res : fresh_res;

  // Inside a burst a beat closes it on last or on reaching MAX_BEATS; otherwise a beat
  // produces a result unless it opens a multi-beat burst.
  assign load_c = accept & (in_acc ? (last | (count_inc == 8'(MAX_BEATS)))
                                   : (~acc_en | last));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c     <= '0;
      beats <= 8'd0;
      trunc <= 1'b0;
      acc   <= '0;
      count <= 8'd0;
    end else begin
      if (load_c) begin
        c     <= load_val;
        beats <= in_acc ? count_inc : 8'd1;
        trunc <= in_acc & ~last;
        state <= HOLD;
      end else if (accept) begin
        state <= ACC;
      end else if ((state == HOLD) && out_ready) begin
        state <= IDLE;
      end

      // A HOLD-state beat is handled exactly like an IDLE beat, so only ACC folds.
      if (accept) begin
        if (in_acc) begin
          acc   <= fold_res;
          count <= count_inc;
        end else if (acc_en) begin
          acc   <= fresh_res;
          count <= 8'd1;
        end
      end
    end
  end

`ifdef LOGIC_GATE_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      c_par <= 1'b0;
    end else if (load_c) begin
      c_par <= ^load_val;
    end
  end
`endif

endmodule
